string_fifo_cmp_avalon: RTL and testbench

STRING_FIFO_CMP_AVALON -- requirements
Module: string_fifo_cmp_avalon

---
 rtl/string_fifo_cmp_avalon.sv | 234 +++++++++++++++++++++++
 tb/tb_string_fifo_cmp_avalon.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_fifo_cmp_avalon.sv
// String compare engine: two word FIFOs behind an Avalon-MM slave, compared byte by byte.
// Define STRING_FIFO_CMP_CASE_FOLD_EN for a case-insensitive compare (ASCII A-Z folded to a-z).
module string_fifo_cmp_avalon #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic [1:0]        dbg_state_o
);
    localparam int LANES = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]     wr_ptr_q [2];
    logic [AW-1:0]     rd_ptr_q [2];
    logic [LW-1:0]     level_q [2];
    logic [7:0]        left_q, left_d;
    logic [15:0]       idx_q, idx_d, result_q, result_d;
    logic              match_q, match_d, err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_W-1:0] readdata_q;

    logic              wr_acc, rd_acc, busy, both_avail, eng_pop, clr, go;
    logic [7:0]        ctl_cnt;
    logic [1:0]        empty, full, host_push, host_pop, pop_ok, push_ok;
    logic [DATA_W-1:0] head [2];
    logic              cmp_hit, cmp_match;
    logic [15:0]       cmp_lane;
    logic [31:0]       status_w;
    logic [DATA_W-1:0] rd_mux;

    // A bus access happens in the cycle chipselect is high together with read or write;
    // there is no wait-request, every access completes in that cycle.
    assign wr_acc  = chipselect && write;
    assign rd_acc  = chipselect && read;
    assign busy    = (state_q == RUN);
    assign ctl_cnt = 8'(writedata >> 8);
    assign clr     = wr_acc && (address == 3'd2) && writedata[1];
    assign go      = wr_acc && (address == 3'd2) && writedata[0] && !writedata[1] && !busy;

    always_comb begin
        for (int f = 0; f < 2; f++) begin
            empty[f]     = (level_q[f] == '0);
            full[f]      = (level_q[f] == LW'(DEPTH));
            head[f]      = mem_q[f][rd_ptr_q[f]];
            host_push[f] = wr_acc && (address == 3'(f));
            host_pop[f]  = rd_acc && (address == 3'(f)) && !busy;
        end
    end

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign both_avail = !empty[0] && !empty[1];
    assign eng_pop    = busy && both_avail;
    assign pop_ok     = (host_pop | {2{eng_pop}}) & ~empty;
    assign push_ok    = host_push & (~full | pop_ok);

    function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef STRING_FIFO_CMP_CASE_FOLD_EN
        return (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
`else
        return b;
`endif
    endfunction

    always_comb begin
        logic [7:0] ba, bb;
        ba        = '0;
        bb        = '0;
        cmp_hit   = 1'b0;
        cmp_match = 1'b0;
        cmp_lane  = '0;
        for (int l = 0; l < LANES; l++) begin
            ba = fold(head[0][8*l +: 8]);
            bb = fold(head[1][8*l +: 8]);
            if (!cmp_hit && (ba != bb || ba == 8'h00)) begin
                cmp_hit   = 1'b1;
                cmp_match = (ba == bb);
                cmp_lane  = 16'(l);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < 2; f++) begin
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                level_q[f]  <= '0;
            end
        end else if (clr) begin
            for (int f = 0; f < 2; f++) begin
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                level_q[f]  <= '0;
            end
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (push_ok[f]) wr_ptr_q[f] <= wr_ptr_q[f] + AW'(1);
                if (pop_ok[f])  rd_ptr_q[f] <= rd_ptr_q[f] + AW'(1);
                level_q[f] <= level_q[f] + LW'(push_ok[f]) - LW'(pop_ok[f]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < 2; f++) begin
            if (push_ok[f]) mem_q[f][wr_ptr_q[f]] <= writedata;
        end
    end

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        idx_d    = idx_q;
        result_d = result_q;
        match_d  = match_q;
        err_d    = err_q;
        ovf_d    = ovf_q | |(host_push & ~push_ok);
        unf_d    = unf_q | |(host_pop & empty);
        if (clr) begin
            state_d  = IDLE;
            left_d   = '0;
            idx_d    = '0;
            result_d = '0;
            match_d  = 1'b0;
            err_d    = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        match_d  = 1'b0;
                        err_d    = 1'b0;
                        idx_d    = '0;
                        result_d = '0;
                        left_d   = ctl_cnt;
                        if (ctl_cnt == 8'd0) begin
                            match_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!both_avail) begin
                        err_d    = 1'b1;
                        match_d  = 1'b0;
                        result_d = idx_q;
                        state_d  = DONE;
                    end else if (cmp_hit) begin
                        match_d  = cmp_match;
                        result_d = idx_q + cmp_lane;
                        state_d  = DONE;
                    end else if (left_q == 8'd1) begin
                        match_d  = 1'b1;
                        result_d = idx_q + 16'(LANES);
                        state_d  = DONE;
                    end else begin
                        left_d = left_q - 8'd1;
                        idx_d  = idx_q + 16'(LANES);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        status_w         = '0;
        status_w[0]      = (state_q == DONE);
        status_w[1]      = busy;
        status_w[2]      = match_q;
        status_w[3]      = err_q;
        status_w[4]      = ovf_q;
        status_w[5]      = unf_q;
        status_w[15:8]   = 8'(level_q[0]);
        status_w[23:16]  = 8'(level_q[1]);
`ifdef STRING_FIFO_CMP_CASE_FOLD_EN
        status_w[31]     = 1'b1;
`endif
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    if (host_pop[0] && !empty[0]) rd_mux = head[0];
            3'd1:    if (host_pop[1] && !empty[1]) rd_mux = head[1];
            3'd2:    rd_mux = DATA_W'(status_w);
            3'd3:    rd_mux = DATA_W'(result_q);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            left_q     <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            match_q  <= match_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (rd_acc) readdata_q <= rd_mux;
        end
    end

    assign readdata    = readdata_q;
    assign irq         = (state_q == DONE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_string_fifo_cmp_avalon.sv
// Bench for string_fifo_cmp_avalon: vector table, directed corner sequences, random ops vs a queue model.
module tb_string_fifo_cmp_avalon;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
`ifdef STRING_FIFO_CMP_CASE_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, chipselect, read, write;
    logic [2:0]    address;
    logic [DW-1:0] writedata, readdata;
    logic          irq;
    logic [1:0]    dbg_state;

    string_fifo_cmp_avalon #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus drivers: called just after a rising edge, each occupies exactly one cycle.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: queues plus the flag set, compare done as a whole-string walk.
    logic [31:0] qa[$], qb[$];
    bit m_done, m_match, m_err, m_ovf, m_unf;
    int m_result;

    function automatic logic [7:0] ref_fold(input logic [7:0] b);
        if (FOLD && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
        return b;
    endfunction

    function automatic logic [31:0] exp_status();
        return {FOLD, 7'd0, 8'(qb.size()), 8'(qa.size()), 2'd0, m_unf, m_ovf, m_err, m_match, 1'b0, m_done};
    endfunction

    function automatic void model_clr();
        qa.delete(); qb.delete();
        m_done = 0; m_match = 0; m_err = 0; m_ovf = 0; m_unf = 0; m_result = 0;
    endfunction

    function automatic void model_go(input int count);
        int idx;
        logic [31:0] wa, wb;
        logic [7:0] ca, cb;
        idx = 0;
        m_done = 1; m_match = 1; m_err = 0; m_result = count * 4;
        for (int w = 0; w < count; w++) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                m_err = 1; m_match = 0; m_result = idx;
                return;
            end
            wa = qa.pop_front();
            wb = qb.pop_front();
            for (int l = 0; l < 4; l++) begin
                ca = ref_fold(wa[8*l +: 8]);
                cb = ref_fold(wb[8*l +: 8]);
                if (ca != cb) begin
                    m_match = 0; m_result = idx;
                    return;
                end
                if (ca == 8'h00) begin
                    m_result = idx;
                    return;
                end
                idx++;
            end
        end
    endfunction

    task automatic push(input int f, input logic [31:0] d);
        bus_write(3'(f), d);
        if (f == 0) begin
            if (qa.size() < DEPTH) qa.push_back(d); else m_ovf = 1;
        end else begin
            if (qb.size() < DEPTH) qb.push_back(d); else m_ovf = 1;
        end
    endtask

    task automatic pop_chk(input int f);
        logic [31:0] got, exp;
        bus_read(3'(f), got);
        exp = '0;
        if (f == 0) begin
            if (qa.size() > 0) exp = qa.pop_front(); else m_unf = 1;
        end else begin
            if (qb.size() > 0) exp = qb.pop_front(); else m_unf = 1;
        end
        check(f == 0 ? "pop_a" : "pop_b", got, exp);
    endtask

    task automatic status_chk(input string name);
        logic [31:0] got;
        bus_read(3'd2, got);
        check(name, got, exp_status());
        check({name, "_irq"}, 32'(irq), 32'(m_done));
    endtask

    task automatic result_chk(input string name);
        logic [31:0] got;
        bus_read(3'd3, got);
        check(name, got, 32'(m_result));
    endtask

    task automatic go_cmd(input int count);
        bus_write(3'd2, 32'((count << 8) | 1));
        model_go(count);
        idle(count + 2);
    endtask

    task automatic clr_cmd();
        bus_write(3'd2, 32'h2);
        model_clr();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [7:0] b;
        for (int l = 0; l < 4; l++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'h00;
                1, 2, 3: b = 8'h61;
                4, 5:    b = 8'h62;
                6, 7:    b = 8'h41;
                8:       b = 8'h5A;
                default: b = 8'h7A;
            endcase
            w[8*l +: 8] = b;
        end
        return w;
    endfunction

    typedef struct {
        logic [31:0] a_word;
        logic [31:0] b_word;
        bit          b_push;
        int          extra;
        int          count;
        bit          exp_match;
        bit          exp_err;
        int          exp_result;
        int          exp_lvla;
        int          exp_lvlb;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] got, exp, wa, wb;
        int op;

        vecs[0]  = '{32'h64636261, 32'h64636261, 1, 0, 1, 1, 0, 4, 0, 0};
        vecs[1]  = '{32'h64586261, 32'h64636261, 1, 0, 1, 0, 0, 2, 0, 0};
        vecs[2]  = '{32'h00006261, 32'h00006261, 1, 0, 2, 1, 0, 2, 0, 0};
        vecs[3]  = '{32'h00006261, 32'h00006261, 1, 1, 2, 1, 0, 2, 1, 1};
        vecs[4]  = '{32'h64636261, 32'h0,        0, 0, 1, 0, 1, 0, 1, 0};
        vecs[5]  = '{32'h64636261, 32'h12345678, 1, 0, 0, 1, 0, 0, 1, 1};
        vecs[6]  = '{32'h44434241, 32'h64636261, 1, 0, 1, FOLD, 0, FOLD ? 4 : 0, 0, 0};
        vecs[7]  = '{32'h005A4161, 32'h007A6161, 1, 0, 1, FOLD, 0, FOLD ? 3 : 1, 0, 0};
        vecs[8]  = '{32'h0000005B, 32'h0000007B, 1, 0, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{32'h64636200, 32'h99999900, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[10] = '{32'h64636261, 32'h65636261, 1, 0, 1, 0, 0, 3, 0, 0};
        vecs[11] = '{32'h64636261, 32'h64636261, 1, 1, 2, 1, 0, 8, 0, 0};
        vecs[12] = '{32'h64636261, 32'h64636261, 1, 0, 2, 0, 1, 4, 0, 0};
        vecs[13] = '{32'h00000040, 32'h00000060, 1, 0, 1, 0, 0, 0, 0, 0};

        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        model_clr();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        bus_read(3'd2, got);
        check("rst_status", got, {FOLD, 31'd0});
        bus_read(3'd3, got);
        check("rst_result", got, 32'h0);

        // Done visible two cycles after GO; busy seen on the first status read
        bus_write(3'd2, 32'h2);
        bus_write(3'd0, 32'h64636261);
        bus_write(3'd1, 32'h64636261);
        bus_write(3'd2, 32'h0101);
        bus_read(3'd2, got);
        check("go_busy", got, {FOLD, 31'h00010102});
        bus_read(3'd2, got);
        check("go_done", got, {FOLD, 31'h5});
        check("go_irq", 32'(irq), 32'h1);
        bus_read(3'd3, got);
        check("go_result", got, 32'd4);

        // Vector table
        for (int i = 0; i < 14; i++) begin
            bus_write(3'd2, 32'h2);
            bus_write(3'd0, vecs[i].a_word);
            if (vecs[i].b_push) bus_write(3'd1, vecs[i].b_word);
            for (int e = 0; e < vecs[i].extra; e++) begin
                bus_write(3'd0, 32'h11111111);
                bus_write(3'd1, 32'h11111111);
            end
            bus_write(3'd2, 32'((vecs[i].count << 8) | 1));
            idle(vecs[i].count + 2);
            exp = {FOLD, 7'd0, 8'(vecs[i].exp_lvlb), 8'(vecs[i].exp_lvla), 4'd0,
                   vecs[i].exp_err, vecs[i].exp_match, 1'b0, 1'b1};
            bus_read(3'd2, got);
            check($sformatf("vec%0d_status", i), got, exp);
            bus_read(3'd3, got);
            check($sformatf("vec%0d_result", i), got, 32'(vecs[i].exp_result));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'h1);
        end

        // Overflow / underflow with 17 pushes and 17 pops
        clr_cmd();
        for (int i = 0; i < 17; i++) push(0, 32'hA0000000 + 32'(i));
        bus_read(3'd2, got);
        check("ovf_status", got, {FOLD, 31'h00001010});
        for (int i = 0; i < 17; i++) pop_chk(0);
        status_chk("unf_status");
        clr_cmd();
        status_chk("clr_status");

        // Host pop blocked while busy, GO during RUN ignored
        bus_write(3'd2, 32'h2);
        for (int i = 0; i < 3; i++) begin
            bus_write(3'd0, 32'h31323334);
            bus_write(3'd1, 32'h31323334);
        end
        bus_write(3'd2, 32'h0301);
        bus_write(3'd2, 32'h0101);
        bus_read(3'd0, got);
        check("busy_pop", got, 32'h0);
        idle(4);
        bus_read(3'd2, got);
        check("busy_status", got, {FOLD, 31'h5});
        bus_read(3'd3, got);
        check("busy_result", got, 32'd12);

        // Push into a full FIFO in the same cycle as an engine pop
        bus_write(3'd2, 32'h2);
        for (int i = 0; i < 16; i++) begin
            bus_write(3'd0, 32'h61616161 + 32'(i));
            bus_write(3'd1, 32'h61616161 + 32'(i));
        end
        bus_write(3'd2, 32'h0201);
        bus_write(3'd0, 32'hCAFEF00D);
        idle(3);
        bus_read(3'd2, got);
        check("fullpp_status", got, {FOLD, 31'h000E0F05});
        bus_read(3'd3, got);
        check("fullpp_result", got, 32'd8);
        for (int i = 2; i < 17; i++) begin
            bus_read(3'd0, got);
            check($sformatf("fullpp_pop%0d", i), got, (i == 16) ? 32'hCAFEF00D : 32'h61616161 + 32'(i));
        end

        // CLR together with GO acts as CLR only; unmapped addresses
        bus_write(3'd0, 32'h64636261);
        bus_write(3'd1, 32'h64636261);
        bus_write(3'd2, 32'h0103);
        idle(2);
        bus_read(3'd2, got);
        check("clrgo_status", got, {FOLD, 31'd0});
        bus_read(3'd5, got);
        check("addr5_read", got, 32'h0);
        bus_write(3'd6, 32'hFFFFFFFF);
        bus_write(3'd4, 32'h12345678);
        bus_read(3'd2, got);
        check("addr_hi_write", got, {FOLD, 31'd0});

        // Reset in the middle of a 4-word RUN
        for (int i = 0; i < 4; i++) begin
            bus_write(3'd0, 32'h41424344);
            bus_write(3'd1, 32'h41424344);
        end
        bus_write(3'd2, 32'h0401);
        idle(1);
        reset = 1'b1;
        #2;
        check("midrun_irq", 32'(irq), 32'h0);
        check("midrun_readdata", readdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(3'd2, got);
        check("midrun_status", got, {FOLD, 31'd0});
        bus_read(3'd3, got);
        check("midrun_result", got, 32'h0);

        // Random operations against the model
        clr_cmd();
        for (int it = 0; it < 400; it++) begin
            op = $urandom_range(0, 19);
            if (op <= 5) begin
                wa = rand_word();
                wb = $urandom_range(0, 1) ? wa : rand_word();
                push(0, wa);
                push(1, wb);
            end else if (op == 6) begin
                push(0, rand_word());
            end else if (op == 7) begin
                push(1, rand_word());
            end else if (op <= 9) begin
                pop_chk(0);
            end else if (op <= 11) begin
                pop_chk(1);
            end else if (op <= 13) begin
                status_chk("rnd_status");
            end else if (op <= 15) begin
                result_chk("rnd_result");
            end else if (op <= 18) begin
                go_cmd($urandom_range(0, 3));
                status_chk("rnd_go_status");
                result_chk("rnd_go_result");
            end else begin
                clr_cmd();
            end
        end
        status_chk("rnd_final_status");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
